sdram_phy: RTL and testbench

SDRAM_PHY -- requirements
Module: sdram_phy

---
 rtl/sdram_phy_pkg.sv | 33 +++
 rtl/sdram_phy_rsp_fifo.sv | 64 ++++++
 rtl/sdram_phy.sv | 176 +++++++++++++++++
 tb/tb_sdram_phy.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_phy_pkg.sv
// sdram_phy_pkg: shared definitions for the SDRAM PHY.
//   - pin and data widths
//   - command opcode enumeration
//   - RAS/CAS/WE pin encodings (active-low, CSn=0 assumed)
package sdram_phy_pkg;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;
  localparam int DQM_W  = 2;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_ACTIVE    = 3'd1,
    OP_READ      = 3'd2,
    OP_WRITE     = 3'd3,
    OP_PRECHARGE = 3'd4,
    OP_REFRESH   = 3'd5,
    OP_MODE      = 3'd6,
    OP_RSVD      = 3'd7
  } opcode_e;

  // {RASn, CASn, WEn}
  localparam logic [2:0] RCW_NOP       = 3'b111;
  localparam logic [2:0] RCW_ACTIVE    = 3'b011;
  localparam logic [2:0] RCW_READ      = 3'b101;
  localparam logic [2:0] RCW_WRITE     = 3'b100;
  localparam logic [2:0] RCW_PRECHARGE = 3'b010;
  localparam logic [2:0] RCW_REFRESH   = 3'b001;
  localparam logic [2:0] RCW_MODE      = 3'b000;

endpackage

// File: rtl/sdram_phy_rsp_fifo.sv
// sdram_phy_rsp_fifo: synchronous read-response FIFO.
//   clk, rst_n        : clock, asynchronous active-low reset (clears contents)
//   push, push_data   : write one word
//   pop               : consume the head word when valid
//   valid, data       : head-of-queue status and word (held until popped)
// Push and pop in the same cycle leave the occupancy unchanged.
module sdram_phy_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop against occupancy so a stray request never corrupts state.
  always_comb begin
    do_pop_s  = pop & (count_r != {(PTR_W + 1){1'b0}});
    do_push_s = push & ((count_r != COUNT_FULL) | do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = (count_r != {(PTR_W + 1){1'b0}});
  assign data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/sdram_phy.sv
// sdram_phy: registered SDRAM pin driver with in-order read-response return.
//   io_axiClk / io_asyncResetn : single clock, async active-low reset
//   io_cmd_*                   : command stream (valid/ready), opcode/addr/ba/data/mask
//   io_rsp_*                   : read data stream (valid/ready), in command order
//   io_sdram_*                 : registered SDRAM pins and DQ pad data/enable
// A command accepted in cycle N drives the pins in cycle N+1. Read data is
// sampled CAS_LATENCY cycles after the READ pin cycle and queued. Flow control
// is credit based so the response FIFO can never overflow.
module sdram_phy
  import sdram_phy_pkg::*;
#(
  parameter int CAS_LATENCY = 3,
  parameter int RSP_DEPTH   = 4
) (
  input  logic              io_axiClk,
  input  logic              io_asyncResetn,
  input  logic              io_cmd_valid,
  output logic              io_cmd_ready,
  input  logic [OP_W-1:0]   io_cmd_payload_opcode,
  input  logic [ADDR_W-1:0] io_cmd_payload_addr,
  input  logic [BA_W-1:0]   io_cmd_payload_ba,
  input  logic [DQ_W-1:0]   io_cmd_payload_data,
  input  logic [DQM_W-1:0]  io_cmd_payload_mask,
  output logic              io_rsp_valid,
  input  logic              io_rsp_ready,
  output logic [DQ_W-1:0]   io_rsp_payload_data,
  output logic [ADDR_W-1:0] io_sdram_ADDR,
  output logic [BA_W-1:0]   io_sdram_BA,
  output logic [DQM_W-1:0]  io_sdram_DQM,
  output logic              io_sdram_CSn,
  output logic              io_sdram_RASn,
  output logic              io_sdram_CASn,
  output logic              io_sdram_WEn,
  output logic              io_sdram_CKE,
  input  logic [DQ_W-1:0]   io_sdram_DQ_read,
  output logic [DQ_W-1:0]   io_sdram_DQ_write,
  output logic              io_sdram_DQ_writeEnable
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(RSP_DEPTH);

  logic              cmd_fire_s;
  opcode_e           op_s;
  logic [2:0]        rcw_s;
  logic              is_nop_s;
  logic              is_read_s;
  logic              is_write_s;

  logic              csn_r;
  logic              cke_r;
  logic [2:0]        rcw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BA_W-1:0]   ba_r;
  logic [DQM_W-1:0]  dqm_r;
  logic [DQ_W-1:0]   dq_out_r;
  logic              dq_oe_r;

  logic [CAS_LATENCY:0] rd_sr_r;
  logic [CNT_W-1:0]     credits_r;
  logic [CNT_W-1:0]     credits_next_s;
  logic                 cmd_ready_r;

  logic              rsp_push_s;
  logic              rsp_pop_s;
  logic              rsp_valid_s;
  logic [DQ_W-1:0]   rsp_data_s;

  // Decode the accepted command into its pin encoding and class flags.
  always_comb begin
    cmd_fire_s = io_cmd_valid & cmd_ready_r;
    op_s       = opcode_e'(io_cmd_payload_opcode);
    rcw_s      = RCW_NOP;
    is_nop_s   = 1'b1;
    is_read_s  = 1'b0;
    is_write_s = 1'b0;
    if (cmd_fire_s) begin
      case (op_s)
        OP_ACTIVE:    begin rcw_s = RCW_ACTIVE;    is_nop_s = 1'b0; end
        OP_READ:      begin rcw_s = RCW_READ;      is_nop_s = 1'b0; is_read_s = 1'b1; end
        OP_WRITE:     begin rcw_s = RCW_WRITE;     is_nop_s = 1'b0; is_write_s = 1'b1; end
        OP_PRECHARGE: begin rcw_s = RCW_PRECHARGE; is_nop_s = 1'b0; end
        OP_REFRESH:   begin rcw_s = RCW_REFRESH;   is_nop_s = 1'b0; end
        OP_MODE:      begin rcw_s = RCW_MODE;      is_nop_s = 1'b0; end
        default:      begin rcw_s = RCW_NOP;       is_nop_s = 1'b1; end
      endcase
    end else begin
      rcw_s    = RCW_NOP;
      is_nop_s = 1'b1;
    end
  end

  // SDRAM pin registers; ADDR/BA hold across NOPs, DQM is 00 except on WRITE.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      csn_r    <= 1'b1;
      cke_r    <= 1'b0;
      rcw_r    <= RCW_NOP;
      addr_r   <= {ADDR_W{1'b0}};
      ba_r     <= {BA_W{1'b0}};
      dqm_r    <= {DQM_W{1'b1}};
      dq_out_r <= {DQ_W{1'b0}};
      dq_oe_r  <= 1'b0;
    end else begin
      csn_r   <= 1'b0;
      cke_r   <= 1'b1;
      rcw_r   <= rcw_s;
      dq_oe_r <= is_write_s;
      dqm_r   <= is_write_s ? ~io_cmd_payload_mask : {DQM_W{1'b0}};
      if (!is_nop_s) begin
        addr_r <= io_cmd_payload_addr;
        ba_r   <= io_cmd_payload_ba;
      end
      if (is_write_s) begin
        dq_out_r <= io_cmd_payload_data;
      end
    end
  end

  // Credit bookkeeping: a READ takes a credit, a response pop returns one.
  // The shift-to-FIFO transfer moves a credit between the two and is neutral.
  always_comb begin
    credits_next_s = credits_r;
    case ({is_read_s, rsp_pop_s})
      2'b10:   credits_next_s = credits_r + CNT_W'(1'b1);
      2'b01:   credits_next_s = credits_r - CNT_W'(1'b1);
      default: credits_next_s = credits_r;
    endcase
  end

  // In-flight read tags and the registered credit/ready state.
  always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      rd_sr_r     <= {(CAS_LATENCY + 1){1'b0}};
      credits_r   <= {CNT_W{1'b0}};
      cmd_ready_r <= 1'b0;
    end else begin
      rd_sr_r     <= {rd_sr_r[CAS_LATENCY-1:0], is_read_s};
      credits_r   <= credits_next_s;
      cmd_ready_r <= (credits_next_s != CREDIT_MAX);
    end
  end

  // Tag reaches the last stage during the cycle the SDRAM drives the read
  // data; the FIFO slot captures the pad at the end of that same cycle.
  assign rsp_push_s = rd_sr_r[CAS_LATENCY];
  assign rsp_pop_s  = rsp_valid_s & io_rsp_ready;

  sdram_phy_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DQ_W)
  ) u_rsp_fifo (
    .clk       (io_axiClk),
    .rst_n     (io_asyncResetn),
    .push      (rsp_push_s),
    .push_data (io_sdram_DQ_read),
    .pop       (rsp_pop_s),
    .valid     (rsp_valid_s),
    .data      (rsp_data_s)
  );

  assign io_cmd_ready            = cmd_ready_r;
  assign io_rsp_valid            = rsp_valid_s;
  assign io_rsp_payload_data     = rsp_data_s;
  assign io_sdram_CSn            = csn_r;
  assign io_sdram_RASn           = rcw_r[2];
  assign io_sdram_CASn           = rcw_r[1];
  assign io_sdram_WEn            = rcw_r[0];
  assign io_sdram_CKE            = cke_r;
  assign io_sdram_ADDR           = addr_r;
  assign io_sdram_BA             = ba_r;
  assign io_sdram_DQM            = dqm_r;
  assign io_sdram_DQ_write       = dq_out_r;
  assign io_sdram_DQ_writeEnable = dq_oe_r;

endmodule

// File: tb/tb_sdram_phy.sv
// tb_sdram_phy: randomized self-checking bench for sdram_phy.
// The reference model works per cycle from the command rules: pins follow the
// previous cycle's accepted command, a READ accepted in cycle N returns the DQ
// value driven in cycle N+1+CL, visible as a response from N+CL+2, and command
// acceptance is allowed while unanswered reads are fewer than the FIFO depth.
module tb_sdram_phy;

  localparam int CL    = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_cmd_valid;
  logic        io_cmd_ready;
  logic [2:0]  io_cmd_payload_opcode;
  logic [12:0] io_cmd_payload_addr;
  logic [1:0]  io_cmd_payload_ba;
  logic [15:0] io_cmd_payload_data;
  logic [1:0]  io_cmd_payload_mask;
  logic        io_rsp_valid;
  logic        io_rsp_ready;
  logic [15:0] io_rsp_payload_data;
  logic [12:0] io_sdram_ADDR;
  logic [1:0]  io_sdram_BA;
  logic [1:0]  io_sdram_DQM;
  logic        io_sdram_CSn;
  logic        io_sdram_RASn;
  logic        io_sdram_CASn;
  logic        io_sdram_WEn;
  logic        io_sdram_CKE;
  logic [15:0] dq_rd;
  logic [15:0] io_sdram_DQ_write;
  logic        io_sdram_DQ_writeEnable;

  always #5 clk = ~clk;

  sdram_phy #(
    .CAS_LATENCY (CL),
    .RSP_DEPTH   (DEPTH)
  ) dut (
    .io_axiClk               (clk),
    .io_asyncResetn          (rst_n),
    .io_cmd_valid            (io_cmd_valid),
    .io_cmd_ready            (io_cmd_ready),
    .io_cmd_payload_opcode   (io_cmd_payload_opcode),
    .io_cmd_payload_addr     (io_cmd_payload_addr),
    .io_cmd_payload_ba       (io_cmd_payload_ba),
    .io_cmd_payload_data     (io_cmd_payload_data),
    .io_cmd_payload_mask     (io_cmd_payload_mask),
    .io_rsp_valid            (io_rsp_valid),
    .io_rsp_ready            (io_rsp_ready),
    .io_rsp_payload_data     (io_rsp_payload_data),
    .io_sdram_ADDR           (io_sdram_ADDR),
    .io_sdram_BA             (io_sdram_BA),
    .io_sdram_DQM            (io_sdram_DQM),
    .io_sdram_CSn            (io_sdram_CSn),
    .io_sdram_RASn           (io_sdram_RASn),
    .io_sdram_CASn           (io_sdram_CASn),
    .io_sdram_WEn            (io_sdram_WEn),
    .io_sdram_CKE            (io_sdram_CKE),
    .io_sdram_DQ_read        (dq_rd),
    .io_sdram_DQ_write       (io_sdram_DQ_write),
    .io_sdram_DQ_writeEnable (io_sdram_DQ_writeEnable)
  );

  // {RASn,CASn,WEn} per opcode 0..7 (0 and 7 are NOP)
  logic [2:0] rcw_tab [8] = '{3'b111, 3'b011, 3'b101, 3'b100,
                              3'b010, 3'b001, 3'b000, 3'b111};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model state
  int          outstanding;
  int          macc;
  int          ret_q[$];
  logic [15:0] exp_q[$];
  logic        e_csn, e_cke, e_we;
  logic [2:0]  e_rcw;
  logic [12:0] e_addr;
  logic [1:0]  e_ba, e_dqm;
  logic [15:0] e_dq;

  // observation
  int          obs_acc = 0;
  int          obs_rsp = 0;
  int          smp_cyc;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        dq_fix_en = 1'b0;
  logic [15:0] dq_fix    = 16'h0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [12:0] a,
                       input logic [1:0] b, input logic [15:0] d, input logic [1:0] m);
    io_cmd_valid          = v;
    io_cmd_payload_opcode = op;
    io_cmd_payload_addr   = a;
    io_cmd_payload_ba     = b;
    io_cmd_payload_data   = d;
    io_cmd_payload_mask   = m;
  endtask

  task automatic model_reset();
    outstanding = 0;
    ret_q.delete();
    exp_q.delete();
    e_csn  = 1'b0;
    e_cke  = 1'b1;
    e_rcw  = 3'b111;
    e_addr = 13'h0000;
    e_ba   = 2'b00;
    e_dqm  = 2'b00;
    e_we   = 1'b0;
    e_dq   = 16'h0000;
  endtask

  // One clock cycle: check at negedge, advance the model, move past posedge.
  task automatic tick();
    logic       m_ready, m_valid, acc;
    logic [2:0] op;
    @(negedge clk);
    smp_cyc   = cyc;
    smp_valid = io_rsp_valid;
    smp_data  = io_rsp_payload_data;
    if (io_cmd_valid && io_cmd_ready) obs_acc++;
    if (io_rsp_valid && io_rsp_ready) obs_rsp++;
    m_ready = (outstanding < DEPTH);
    m_valid = (exp_q.size() > 0);
    check_val("cmd_ready", 32'(io_cmd_ready), 32'(m_ready));
    check_val("rsp_valid", 32'(io_rsp_valid), 32'(m_valid));
    if (m_valid) check_val("rsp_data", 32'(io_rsp_payload_data), 32'(exp_q[0]));
    check_val("CSn", 32'(io_sdram_CSn), 32'(e_csn));
    check_val("CKE", 32'(io_sdram_CKE), 32'(e_cke));
    check_val("RCW", 32'({io_sdram_RASn, io_sdram_CASn, io_sdram_WEn}), 32'(e_rcw));
    check_val("ADDR", 32'(io_sdram_ADDR), 32'(e_addr));
    check_val("BA", 32'(io_sdram_BA), 32'(e_ba));
    check_val("DQM", 32'(io_sdram_DQM), 32'(e_dqm));
    check_val("DQ_oe", 32'(io_sdram_DQ_writeEnable), 32'(e_we));
    if (e_we) check_val("DQ_write", 32'(io_sdram_DQ_write), 32'(e_dq));
    acc = io_cmd_valid && m_ready;
    op  = io_cmd_payload_opcode;
    if (m_valid && io_rsp_ready) begin
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (ret_q.size() > 0 && ret_q[0] == cyc) begin
      void'(ret_q.pop_front());
      exp_q.push_back(dq_rd);
    end
    if (acc) macc++;
    if (acc && op == 3'd2) begin
      ret_q.push_back(cyc + 1 + CL);
      outstanding++;
    end
    @(posedge clk);
    #1;
    cyc++;
    e_csn = 1'b0;
    e_cke = 1'b1;
    e_rcw = acc ? rcw_tab[op] : 3'b111;
    if (acc && op != 3'd0 && op != 3'd7) begin
      e_addr = io_cmd_payload_addr;
      e_ba   = io_cmd_payload_ba;
    end
    e_we  = acc && (op == 3'd3);
    e_dqm = e_we ? ~io_cmd_payload_mask : 2'b00;
    if (e_we) e_dq = io_cmd_payload_data;
    dq_rd = dq_fix_en ? dq_fix : 16'($urandom);
  endtask

  // Assert reset mid-cycle, check pins immediately, release mid-cycle.
  task automatic apply_reset();
    #2;
    rst_n        = 1'b0;
    io_cmd_valid = 1'b0;
    #1;
    check_val("rst_CSn", 32'(io_sdram_CSn), 32'd1);
    check_val("rst_RCW", 32'({io_sdram_RASn, io_sdram_CASn, io_sdram_WEn}), 32'd7);
    check_val("rst_CKE", 32'(io_sdram_CKE), 32'd0);
    check_val("rst_ADDR", 32'(io_sdram_ADDR), 32'd0);
    check_val("rst_BA", 32'(io_sdram_BA), 32'd0);
    check_val("rst_DQM", 32'(io_sdram_DQM), 32'd3);
    check_val("rst_DQ_write", 32'(io_sdram_DQ_write), 32'd0);
    check_val("rst_DQ_oe", 32'(io_sdram_DQ_writeEnable), 32'd0);
    check_val("rst_cmd_ready", 32'(io_cmd_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(io_rsp_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cyc = cyc + 3;
    dq_rd = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a0, r0, m0, acc_c, first;
    logic [15:0] fdata;
    rst_n = 1'b0;
    macc  = 0;
    dq_rd = 16'h0000;
    io_rsp_ready = 1'b0;
    drive(1'b0, 3'd0, 13'h0, 2'd0, 16'h0, 2'b00);
    model_reset();
    #12;
    apply_reset();

    // ACTIVE then WRITE, then opcode 7 and idle must keep ADDR/BA
    io_rsp_ready = 1'b1;
    drive(1'b1, 3'd1, 13'h0155, 2'd2, 16'h0000, 2'b00); tick();
    drive(1'b1, 3'd3, 13'h0010, 2'd2, 16'hA5C3, 2'b01); tick();
    drive(1'b1, 3'd7, 13'h1FFF, 2'd1, 16'hFFFF, 2'b11); tick();
    check_val("wr_DQM", 32'(io_sdram_DQM), 32'd0);
    drive(1'b0, 3'd6, 13'h0AAA, 2'd3, 16'h0000, 2'b00); tick();
    check_val("nop_ADDR", 32'(io_sdram_ADDR), 32'h010);
    tick();

    // single READ latency with a fixed SDRAM return value
    dq_fix_en = 1'b1;
    dq_fix    = 16'h1234;
    drive(1'b1, 3'd2, 13'h0020, 2'd1, 16'h0000, 2'b00); tick();
    acc_c = smp_cyc;
    io_cmd_valid = 1'b0;
    first = -1;
    fdata = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (smp_valid && first < 0) begin
        first = smp_cyc;
        fdata = smp_data;
      end
    end
    check_val("rd_latency", 32'(first - acc_c), 32'(CL + 2));
    check_val("rd_data", 32'(fdata), 32'h1234);
    dq_fix_en = 1'b0;

    // six READs with consumer stalled: only DEPTH accepted
    io_rsp_ready = 1'b0;
    a0 = obs_acc;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3'd2, 13'(k), 2'(k), 16'h0000, 2'b00);
      tick();
    end
    io_cmd_valid = 1'b0;
    tick();
    check_val("fill_acc", 32'(obs_acc - a0), 32'd4);
    check_val("fill_ready", 32'(io_cmd_ready), 32'd0);
    io_rsp_ready = 1'b1;
    r0 = obs_rsp;
    repeat (8) tick();
    check_val("drain_rsp", 32'(obs_rsp - r0), 32'd4);
    drive(1'b1, 3'd2, 13'h0033, 2'd0, 16'h0000, 2'b00); tick();
    check_val("resume_acc", 32'(obs_acc - a0), 32'd5);
    io_cmd_valid = 1'b0;
    repeat (8) tick();

    // sustained READs with consumer always ready
    a0 = obs_acc;
    r0 = obs_rsp;
    m0 = macc;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 3'd2, 13'($urandom), 2'($urandom), 16'h0000, 2'b00);
      tick();
    end
    io_cmd_valid = 1'b0;
    repeat (12) tick();
    check_val("sust_acc", 32'(obs_acc - a0), 32'(macc - m0));
    check_val("sust_rsp", 32'(obs_rsp - r0), 32'(obs_acc - a0));

    // random mix of all opcodes, idle gaps and consumer stalls
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 13'($urandom),
            2'($urandom), 16'($urandom), 2'($urandom));
      io_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    io_cmd_valid = 1'b0;
    io_rsp_ready = 1'b1;
    repeat (12) tick();

    // reset with two reads in flight: nothing may emerge afterwards
    drive(1'b1, 3'd2, 13'h0044, 2'd1, 16'h0000, 2'b00); tick();
    drive(1'b1, 3'd2, 13'h0045, 2'd1, 16'h0000, 2'b00); tick();
    apply_reset();
    r0 = obs_rsp;
    repeat (15) tick();
    check_val("post_rst_rsp", 32'(obs_rsp - r0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
